mod_mult_seq: RTL and testbench
===============================

// Module: mod_mult_seq
// PURPOSE
// - Sequential, parametrised modular multiplier: z = (a * b) mod MODULUS; generalises the fixed-constant LUT multipliers to two run-time operands.
// - Digit-serial interleaved (Horner, MSB digit of b first), DIGIT bits of b per cycle; one operation in flight; valid/ready on both sides.
// - Sits beside the combinational mod-503 multiplier tables for area-constrained datapaths that accept multi-cycle latency.
// PARAMETERS
// - MODULUS  503  modulus M; must satisfy 2^(W-1) < M < 2^W
// - W        9    operand/result width in bits
// - DIGIT    3    bits of b consumed per RUN cycle; legal 1..4
// PORTS
// - clk        in   1  clock, rising edge
// - rst_n      in   1  asynchronous active-low reset
// - in_valid   in   1  operand pair valid
// - in_ready   out  1  block can accept operands
// - in_a       in   W  operand a, any value 0..2^W-1
// - in_b       in   W  operand b, any value 0..2^W-1
// - out_valid  out  1  result valid
// - out_ready  in   1  consumer accepts result
// - out_z      out  W  result, always 0..M-1
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_z=0, acc=0, step count=0.
// - STEPS = ceil(W/DIGIT); b zero-extended on the MSB side to STEPS*DIGIT bits.
// - FSM IDLE -> RUN -> DONE -> IDLE.
// - IDLE: in_ready=1. On in_valid&&in_ready edge: latch a' = (a>=M)?a-M:a, b' = (b>=M)?b-M:b (one conditional subtract is sufficient given the M range); acc=0; cnt=0; go to RUN.
// - RUN: in_ready=0. Each edge: t = (acc << DIGIT) + a' * digit[STEPS-1-cnt]; acc = t mod M; cnt++.
//   - Reduction: t < 2^(DIGIT+1)*M. Select largest k in 0..2^(DIGIT+1)-1 with k*M <= t; acc = t - k*M. Parallel compare against constant multiples, no iteration.
//   - Intermediate width W+DIGIT+1 bits, unsigned, no truncation before reduction.
//   - After the STEPS-th edge: out_z=acc, out_valid=1, go to DONE.
// - Latency: out_valid rises exactly STEPS cycles after the accepting edge (3 for defaults).
// - DONE: out_valid=1; out_z stable until handshake. On out_valid&&out_ready edge: out_valid=0, go to IDLE; in_ready=1 from the next cycle (no same-cycle bypass, so max throughput one result per STEPS+2 cycles).
// - in_valid during RUN/DONE is ignored; in_a/in_b are sampled only on the accepting edge.
// - out_ready while not in DONE has no effect.
// - Reset mid-operation: result discarded, no out_valid pulse, IDLE on release.
// - Special cases need no extra logic: a'=0 or b'=0 gives 0; M-1 squared gives 1.
// STRUCTURE
// - Package mod_mult_pkg: default MODULUS/W/DIGIT, state enum typedef {IDLE,RUN,DONE}, function steps(W,DIGIT), function for the k*M constant table.
// - One combinational sub-module mod_digit_step (acc, a', digit -> next acc): shift, partial product, parallel compare/select reduction. Top holds FSM, counter, operand and accumulator registers.
// - Parameter legality (M range, DIGIT range) checked at elaboration; illegal settings are a fatal error.
// TESTING
// - a=5, b=7 -> out_z=35 after exactly 3 cycles; in_ready low for the duration.
// - a=64, b=3 -> 192; a=3, b=64 -> 192 (operand order irrelevant).
// - a=502, b=502 -> 1; a=300, b=300 -> 466; a=0, b=502 -> 0.
// - a=511 (pre-reduced to 8), b=2 -> 16; a=503, b=503 -> 0.
// - Backpressure: out_ready low 5 cycles -> out_valid/out_z held at the same value; new in_valid ignored until IDLE.
// - rst_n low during RUN cnt=1 -> all outputs at reset values immediately; next op 10*10 -> 100 correct.
// - Sweep DIGIT=1,2,4 with random a,b vs. reference model (a*b)%M; latency equals STEPS in every case.

Source files
------------

// File: rtl/mod_mult_pkg.sv
// Shared defaults, FSM state type and constant helpers for the sequential modular multiplier.
package mod_mult_pkg;

  localparam int unsigned DEF_MODULUS = 503;
  localparam int unsigned DEF_W       = 9;
  localparam int unsigned DEF_DIGIT   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mm_state_e;

  function automatic int unsigned steps(input int unsigned w, input int unsigned digit);
    return (w + digit - 1) / digit;
  endfunction

  // k*M, used to build the constant compare table of the reduction stage.
  function automatic longint unsigned m_multiple(input int unsigned k, input int unsigned m);
    return 64'(k) * 64'(m);
  endfunction

endpackage

// File: rtl/mod_digit_step.sv
// One Horner step: acc_o = ((acc_i << DIGIT) + a_i * digit_i) mod MODULUS, purely combinational.
module mod_digit_step
  import mod_mult_pkg::*;
#(
  parameter int unsigned MODULUS = DEF_MODULUS,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned DIGIT   = DEF_DIGIT
) (
  input  logic [W-1:0]     acc_i,
  input  logic [W-1:0]     a_i,
  input  logic [DIGIT-1:0] digit_i,
  output logic [W-1:0]     acc_o
);

  localparam int unsigned TW = W + DIGIT + 1;
  localparam int unsigned NK = 2 ** (DIGIT + 1);

  logic [TW-1:0] t;
  logic [TW-1:0] rem;

  // acc_i, a_i < M, so t < 2^(DIGIT+1)*M: the largest k*M not above t is
  // found by comparing t against every constant multiple in parallel.
  always_comb begin
    t   = (TW'(acc_i) << DIGIT) + TW'(a_i) * TW'(digit_i);
    rem = t;
    for (int unsigned k = 1; k < NK; k++) begin
      if (t >= TW'(m_multiple(k, MODULUS))) begin
        rem = t - TW'(m_multiple(k, MODULUS));
      end
    end
  end

  assign acc_o = W'(rem);

endmodule

// File: rtl/mod_mult_seq.sv
// Digit-serial interleaved modular multiplier z = (a*b) mod MODULUS, MSB digit of b first,
// one operation in flight.
module mod_mult_seq
  import mod_mult_pkg::*;
#(
  parameter int unsigned MODULUS = DEF_MODULUS,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned DIGIT   = DEF_DIGIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z
);

  localparam int unsigned STEPS = steps(W, DIGIT);
  localparam int unsigned BW    = STEPS * DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [W-1:0] M_W  = W'(MODULUS);

  if (!((MODULUS > (2 ** (W - 1))) && (MODULUS < (2 ** W)))) begin : g_bad_modulus
    $fatal(1, "mod_mult_seq: MODULUS must lie strictly between 2^(W-1) and 2^W");
  end
  if (!((DIGIT >= 1) && (DIGIT <= 4))) begin : g_bad_digit
    $fatal(1, "mod_mult_seq: DIGIT must be 1..4");
  end

  mm_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [BW-1:0] b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  z_q, z_d;
  logic [W-1:0]  acc_step;

  mod_digit_step #(
    .MODULUS(MODULUS),
    .W      (W),
    .DIGIT  (DIGIT)
  ) u_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .digit_i(b_q[BW-1 -: DIGIT]),
    .acc_o  (acc_step)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; out_z is held
  // stable while out_valid waits for out_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = (in_a >= M_W) ? (in_a - M_W) : in_a;
          b_d     = BW'((in_b >= M_W) ? (in_b - M_W) : in_b);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // b is kept left-aligned so the current digit is always its top slice.
        acc_d = acc_step;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          z_d     = acc_step;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_z     = z_q;

endmodule

// File: tb/tb_mod_mult_seq.sv
// Directed bench for mod_mult_seq: default DUT plus DIGIT=1/2/4 instances run in lockstep.
module tb_mod_mult_seq;

  localparam int STEPS_M = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT (defaults) ----------------
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_a = '0;
  logic [8:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_z;

  mod_mult_seq u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z    (out_z)
  );

  // ---------------- DIGIT sweep instances ----------------
  logic       sw_valid  = 1'b0;
  logic       sw_oready = 1'b1;
  logic [8:0] sw_a = '0;
  logic [8:0] sw_b = '0;
  logic [2:0] sw_rdy;
  logic [2:0] sw_ov;
  logic [8:0] sw_z [3];

  mod_mult_seq #(.DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[0]),
    .in_a(sw_a), .in_b(sw_b), .out_valid(sw_ov[0]), .out_ready(sw_oready), .out_z(sw_z[0])
  );
  mod_mult_seq #(.DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[1]),
    .in_a(sw_a), .in_b(sw_b), .out_valid(sw_ov[1]), .out_ready(sw_oready), .out_z(sw_z[1])
  );
  mod_mult_seq #(.DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[2]),
    .in_a(sw_a), .in_b(sw_b), .out_valid(sw_ov[2]), .out_ready(sw_oready), .out_z(sw_z[2])
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [8:0] a, input logic [8:0] b, input string tag, input int hold);
    int   lat;
    int   guard;
    bit   seen;
    bit   busy_ok;
    logic [31:0] exp;
    exp = exp_q.pop_front();
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 9'($urandom_range(0, 511));
    in_b = 9'($urandom_range(0, 511));
    lat = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (in_ready) busy_ok = 1'b0;
      seen = out_valid;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(STEPS_M));
    chk({tag, "_z"}, 32'(out_z), exp);
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = 9'd1;
      in_b = 9'd1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_hold%0d_valid", tag, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s_hold%0d_z", tag, i), 32'(out_z), exp);
      chk($sformatf("%s_hold%0d_ready", tag, i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic sweep(input logic [8:0] a, input logic [8:0] b, input logic [8:0] exp);
    int lat_exp [3];
    bit [2:0] seen;
    int guard;
    lat_exp = '{9, 5, 3};
    seen = '0;
    guard = 0;
    @(negedge clk);
    while (sw_rdy != 3'b111 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    sw_a = a;
    sw_b = b;
    sw_valid = 1'b1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (sw_ov[i] && !seen[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("sw%0d_%0dx%0d_z", i, a, b), 32'(sw_z[i]), 32'(exp));
          chk($sformatf("sw%0d_%0dx%0d_lat", i, a, b), 32'(c), 32'(lat_exp[i]));
        end
      end
    end
    chk($sformatf("sw_%0dx%0d_seen", a, b), 32'(seen), 32'd7);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] z;
  } vec_t;

  vec_t main_vecs [9];
  vec_t sw_vecs [8];

  initial begin
    main_vecs = '{
      '{9'd5,   9'd7,   9'd35},
      '{9'd64,  9'd3,   9'd192},
      '{9'd3,   9'd64,  9'd192},
      '{9'd502, 9'd502, 9'd1},
      '{9'd300, 9'd300, 9'd466},
      '{9'd0,   9'd502, 9'd0},
      '{9'd511, 9'd2,   9'd16},
      '{9'd503, 9'd503, 9'd0},
      '{9'd123, 9'd456, 9'd255}
    };
    sw_vecs = '{
      '{9'd123, 9'd456, 9'd255},
      '{9'd511, 9'd511, 9'd64},
      '{9'd250, 9'd2,   9'd500},
      '{9'd400, 9'd400, 9'd46},
      '{9'd300, 9'd300, 9'd466},
      '{9'd502, 9'd1,   9'd502},
      '{9'd0,   9'd77,  9'd0},
      '{9'd502, 9'd502, 9'd1}
    };

    #2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_z", 32'(out_z), 32'd0);
    rst_n = 1'b1;

    foreach (main_vecs[i]) begin
      exp_q.push_back(32'(main_vecs[i].z));
      do_op(main_vecs[i].a, main_vecs[i].b, $sformatf("op%0d", i), 0);
    end

    // Result held under backpressure while new operands are offered.
    exp_q.push_back(32'd192);
    do_op(9'd64, 9'd3, "bp", 5);

    // Reset in the middle of RUN (after the first digit step).
    begin
      bit any_valid;
      @(negedge clk);
      in_a = 9'd5;
      in_b = 9'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_z", 32'(out_z), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      any_valid = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (out_valid) any_valid = 1'b1;
      end
      chk("midrst_no_pulse", 32'(any_valid), 32'd0);
    end
    exp_q.push_back(32'd100);
    do_op(9'd10, 9'd10, "after_rst", 0);

    foreach (sw_vecs[i]) begin
      sweep(sw_vecs[i].a, sw_vecs[i].b, sw_vecs[i].z);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
